md_unit: RTL and testbench

Multiply/divide unit and sequencer for the 5-stage MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo operations from the E stage, holds HI/LO, and models multi-cycle latency with a busy counter. It produces the extra stall term that the hazard unit ORs into its stall output when a D-stage multiply/divide instruction would collide with an operation in flight.

---
 rtl/md_unit.sv | 116 +++++++++++
 tb/tb_md_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// rtl/md_unit.sv - HI/LO multiply/divide unit with busy-counter latency model and D-stage stall term.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_md,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] p_hi, p_lo, p_hi_n, p_lo_n, hi_n, lo_n;

  logic               is_mul;
  logic               div_zero;
  logic               div_ovf;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        sdvs, udvs;
  logic signed [31:0] sq, sr;
  logic [31:0]        uq, ur;
  logic [63:0]        result;

  assign busy     = (state == BUSY);
  assign start    = (e_md_op >= 4'd1) && (e_md_op <= 4'd4) && !busy;
  assign stall_md = d_md & (start | busy);
  assign md_out   = (e_md_op == 4'd5) ? hi : (e_md_op == 4'd6) ? lo : 32'd0;
  assign is_mul   = (e_md_op == 4'd1) || (e_md_op == 4'd2);

  assign prod_s = $signed({{32{e_rs[31]}}, e_rs}) * $signed({{32{e_rt[31]}}, e_rt});
  assign prod_u = {32'd0, e_rs} * {32'd0, e_rt};

  // Dividing the most negative value by 1 yields exactly the wrapped result of
  // dividing by -1 (quotient 0x80000000, remainder 0), so swap the divisor.
  assign div_zero = (e_rt == 32'd0);
  assign div_ovf  = (e_rs == 32'h8000_0000) && (e_rt == 32'hFFFF_FFFF);
  assign sdvs     = (div_zero || div_ovf) ? 32'd1 : e_rt;
  assign udvs     = div_zero ? 32'd1 : e_rt;
  assign sq       = $signed(e_rs) / $signed(sdvs);
  assign sr       = $signed(e_rs) % $signed(sdvs);
  assign uq       = e_rs / udvs;
  assign ur       = e_rs % udvs;

  always_comb begin
    result = {hi, lo};
    case (e_md_op)
      4'd1:    result = prod_s;
      4'd2:    result = prod_u;
      4'd3:    if (!div_zero) result = {sr, sq};
      4'd4:    if (!div_zero) result = {ur, uq};
      default: result = {hi, lo};
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p_hi_n  = p_hi;
    p_lo_n  = p_lo;
    hi_n    = hi;
    lo_n    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          {p_hi_n, p_lo_n} = result;
          cnt_n            = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          state_n          = BUSY;
        end else if (e_md_op == 4'd7) begin
          hi_n = e_rs;
        end else if (e_md_op == 4'd8) begin
          lo_n = e_rs;
        end
      end
      BUSY: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          hi_n    = p_hi;
          lo_n    = p_lo;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      p_hi  <= p_hi_n;
      p_lo  <= p_lo_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - Directed and randomized bench for md_unit against a cycle-level reference model.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs, e_rt;
  logic        d_md;
  logic        start, busy, stall_md;
  logic [31:0] hi, lo, md_out;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .e_md_op(e_md_op), .e_rs(e_rs), .e_rt(e_rt),
    .d_md(d_md), .start(start), .busy(busy), .stall_md(stall_md),
    .hi(hi), .lo(lo), .md_out(md_out)
  );

  int checks = 0;
  int failures = 0;
  int busy_seen = 0;

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] rs,
                                              input logic [31:0] rt, input logic [31:0] ch,
                                              input logic [31:0] cl);
    longint a, b, q, r;
    longint unsigned ua, ub, uqq, urr;
    a  = longint'($signed(rs));
    b  = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    case (op)
      4'd1: return 64'(a * b);
      4'd2: return 64'(ua * ub);
      4'd3: begin
        if (rt == 32'd0) return {ch, cl};
        q = a / b;
        r = a % b;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (rt == 32'd0) return {ch, cl};
        uqq = ua / ub;
        urr = ua % ub;
        return {urr[31:0], uqq[31:0]};
      end
      default: return {ch, cl};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic dm);
    logic        exp_start;
    logic [31:0] exp_md;
    logic [63:0] res;
    reset = rst; e_md_op = op; e_rs = rs; e_rt = rt; d_md = dm;
    #3;
    exp_start = (op >= 4'd1) && (op <= 4'd4) && (m_left == 0);
    exp_md    = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    check("busy", 32'(busy), 32'(m_left > 0));
    check("start", 32'(start), 32'(exp_start));
    check("stall_md", 32'(stall_md), 32'(dm && (exp_start || m_left > 0)));
    check("md_out", md_out, exp_md);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    if (busy === 1'b1) busy_seen++;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (exp_start) begin
      res    = ref_result(op, rs, rt, m_hi, m_lo);
      m_phi  = res[63:32];
      m_plo  = res[31:0];
      m_left = (op <= 4'd2) ? MC : DC;
    end else if (op == 4'd7) begin
      m_hi = rs;
    end else if (op == 4'd8) begin
      m_lo = rs;
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; e_md_op = 4'd0; e_rs = 32'd0; e_rt = 32'd0; d_md = 1'b0;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0;
    @(posedge clk);
    #1;
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

    busy_seen = 0;
    cycle(1'b1, 4'd1, 32'hFFFF_FFFF, 32'd3, 1'b0);
    repeat (MC + 1) cycle(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    check("mult_busy_cycles", 32'(busy_seen), 32'(MC));
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFD);

    cycle(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (MC) cycle(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    busy_seen = 0;
    cycle(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    repeat (DC) cycle(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    check("div_busy_cycles", 32'(busy_seen), 32'(DC));
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    cycle(1'b1, 4'd4, 32'd7, 32'd0, 1'b0);
    repeat (DC) cycle(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    check("divz_lo", lo, 32'hFFFF_FFFD);
    check("divz_hi", hi, 32'hFFFF_FFFF);

    cycle(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    repeat (DC) cycle(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    cycle(1'b1, 4'd3, 32'd100, 32'd7, 1'b1);
    repeat (DC) cycle(1'b1, 4'd8, 32'h0000_1234, 32'd0, 1'b1);
    e_md_op = 4'd0; d_md = 1'b1;
    #1;
    check("stall_after_busy", 32'(stall_md), 32'd0);
    check("lo_not_1234", 32'(lo == 32'h0000_1234), 32'd0);
    cycle(1'b1, 4'd0, 32'd0, 32'd0, 1'b1);

    cycle(1'b1, 4'd7, 32'hCAFE_BABE, 32'd0, 1'b0);
    e_md_op = 4'd5;
    #1;
    check("mthi_hi", hi, 32'hCAFE_BABE);
    check("mfhi_md_out", md_out, 32'hCAFE_BABE);
    cycle(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);

    cycle(1'b1, 4'd1, 32'd1234, 32'd5678, 1'b0);
    cycle(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    cycle(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    repeat (MC + 2) cycle(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
    check("rst_no_commit_lo", lo, 32'd0);

    repeat (600) begin
      cycle(($urandom_range(0, 63) != 0), 4'($urandom_range(0, 15)), pick_val(), pick_val(),
            1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
